// File: rtl/next_pc_generator.sv
// Fetch-PC generator: owns the fetch PC register and arbitrates the next PC.
// The candidates, highest priority first, are the interrupt, the oldest
// mispredicting branch channel, a stall/bubble hold, the predictor target,
// and the sequential fetch-block increment.
// A warm-up phase runs after reset. Redirect bubbles are inserted after each
// redirect, and a history-recovery pulse follows each branch redirect.

// Per-channel qualification: a channel only matters when it is a valid misprediction.
module npc_br_lane #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_BYTES = 4
) (
    input  logic                valid,
    input  logic                mispred,
    input  logic [PC_WIDTH-1:0] target,
    output logic                hit,
    output logic [PC_WIDTH-1:0] tgt
);
    localparam logic [PC_WIDTH-1:0] INST_MASK = ~PC_WIDTH'(INST_BYTES - 1);

    assign hit = valid & mispred;
    assign tgt = target & INST_MASK;
endmodule

module next_pc_generator #(
    parameter int                PC_WIDTH      = 32,
    parameter int                FETCH_WIDTH   = 2,
    parameter int                INST_BYTES    = 4,
    parameter int                NUM_BR_PORTS  = 2,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_1000,
    parameter int                WARMUP_CYCLES = 8,
    parameter int                BUBBLE_CYCLES = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stall,
    input  logic [NUM_BR_PORTS-1:0]           brValid,
    input  logic [NUM_BR_PORTS-1:0]           brMispred,
    input  logic [NUM_BR_PORTS*PC_WIDTH-1:0]  brTarget,
    input  logic                              intWE,
    input  logic [PC_WIDTH-1:0]               intAddr,
    input  logic                              predTaken,
    input  logic [PC_WIDTH-1:0]               predTarget,
    output logic [PC_WIDTH-1:0]               pcOut,
    output logic [PC_WIDTH-1:0]               predNextPC,
    output logic                              fetchValid,
    output logic                              recoverBrHistory,
    output logic [(NUM_BR_PORTS > 1 ? $clog2(NUM_BR_PORTS) : 1)-1:0] recoverPort,
    output logic                              warmupDone
);
    localparam int PW          = (NUM_BR_PORTS > 1) ? $clog2(NUM_BR_PORTS) : 1;
    localparam int FETCH_BYTES = FETCH_WIDTH * INST_BYTES;
    localparam int CNT_W       = $clog2(WARMUP_CYCLES + 4) + 1;

    localparam logic [PC_WIDTH-1:0] INST_MASK  = ~PC_WIDTH'(INST_BYTES - 1);
    localparam logic [PC_WIDTH-1:0] BLOCK_MASK = ~PC_WIDTH'(FETCH_BYTES - 1);
    localparam logic [PC_WIDTH-1:0] BLOCK_INC  = PC_WIDTH'(FETCH_BYTES);
    localparam logic [CNT_W-1:0]    WARM_LAST  = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]    BUB_LAST   = CNT_W'(BUBBLE_CYCLES > 0 ? BUBBLE_CYCLES - 1 : 0);

    typedef enum logic [1:0] { S_WARMUP, S_RUN, S_BUBBLE } state_t;

    state_t                                 state;
    logic [CNT_W-1:0]                       cnt;
    logic [PC_WIDTH-1:0]                    pc_q;
    logic [PC_WIDTH-1:0]                    next_pc;
    logic [NUM_BR_PORTS-1:0]                br_hit;
    logic [NUM_BR_PORTS-1:0][PC_WIDTH-1:0]  br_tgt;
    logic                                   br_any;
    logic [PW-1:0]                          br_idx;
    logic [PC_WIDTH-1:0]                    br_sel;
    logic                                   active;
    logic                                   redirect;
    logic                                   br_recover;

    for (genvar g = 0; g < NUM_BR_PORTS; g++) begin : g_lane
        npc_br_lane #(
            .PC_WIDTH  (PC_WIDTH),
            .INST_BYTES(INST_BYTES)
        ) u_lane (
            .valid  (brValid[g]),
            .mispred(brMispred[g]),
            .target (brTarget[g*PC_WIDTH +: PC_WIDTH]),
            .hit    (br_hit[g]),
            .tgt    (br_tgt[g])
        );
    end

    // Oldest mispredicting channel wins: scan downward so the lowest index overrides.
    always_comb begin
        br_any = 1'b0;
        br_idx = '0;
        br_sel = '0;
        for (int i = NUM_BR_PORTS - 1; i >= 0; i--) begin
            if (br_hit[i]) begin
                br_any = 1'b1;
                br_idx = PW'(i);
                br_sel = br_tgt[i];
            end
        end
    end

    assign active     = (state != S_WARMUP);
    assign redirect   = active && (intWE || br_any);
    assign br_recover = active && !intWE && br_any;

    // Next-PC priority mux; warm-up holds the reset vector regardless of inputs.
    always_comb begin
        next_pc = pc_q;
        if (!active)                next_pc = pc_q;
        else if (intWE)             next_pc = intAddr & INST_MASK;
        else if (br_any)            next_pc = br_sel;
        else if (stall)             next_pc = pc_q;
        else if (state == S_BUBBLE) next_pc = pc_q;
        else if (predTaken)         next_pc = predTarget & INST_MASK;
        else                        next_pc = (pc_q & BLOCK_MASK) + BLOCK_INC;
    end

    assign pcOut      = pc_q;
    assign predNextPC = next_pc;
    assign fetchValid = (state == S_RUN) && !stall;

    // PC register, warm-up/bubble sequencing and the recovery pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_WARMUP;
            cnt              <= '0;
            pc_q             <= RESET_VECTOR;
            recoverBrHistory <= 1'b0;
            recoverPort      <= '0;
            warmupDone       <= 1'b0;
        end else begin
            pc_q             <= next_pc;
            recoverBrHistory <= br_recover;
            if (br_recover) recoverPort <= br_idx;
            case (state)
                S_WARMUP: begin
                    if (cnt == WARM_LAST) begin
                        state      <= S_RUN;
                        warmupDone <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (redirect && BUBBLE_CYCLES > 0) begin
                        state <= S_BUBBLE;
                        cnt   <= '0;
                    end
                end
                S_BUBBLE: begin
                    // A fresh redirect restarts the bubble count.
                    if (redirect)              cnt <= '0;
                    else if (cnt == BUB_LAST)  state <= S_RUN;
                    else                       cnt <= cnt + 1'b1;
                end
                default: state <= S_WARMUP;
            endcase
        end
    end
endmodule

// File: tb/tb_next_pc_generator.sv
// Self-checking bench for next_pc_generator: directed scenarios plus a random
// run, all compared against a cycle-level behavioural model.
module tb_next_pc_generator;
    localparam int WU = 8;
    localparam int BB = 1;

    logic        clk, rst, stall, intWE, predTaken;
    logic [1:0]  brValid, brMispred;
    logic [63:0] brTarget;
    logic [31:0] intAddr, predTarget;
    logic [31:0] pcOut, predNextPC;
    logic        fetchValid, recoverBrHistory, warmupDone;
    logic [0:0]  recoverPort;

    int checks = 0;
    int errors = 0;

    // Model state: mode 0=warm-up, 1=run, 2=bubble
    logic [31:0] m_pc;
    int          m_mode, m_wcnt, m_bleft, m_port;
    bit          m_pulse, m_wd;

    next_pc_generator dut (
        .clk(clk), .rst(rst), .stall(stall),
        .brValid(brValid), .brMispred(brMispred), .brTarget(brTarget),
        .intWE(intWE), .intAddr(intAddr),
        .predTaken(predTaken), .predTarget(predTarget),
        .pcOut(pcOut), .predNextPC(predNextPC), .fetchValid(fetchValid),
        .recoverBrHistory(recoverBrHistory), .recoverPort(recoverPort),
        .warmupDone(warmupDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_in();
        stall = 0; intWE = 0; predTaken = 0;
        brValid = 0; brMispred = 0; brTarget = 0;
        intAddr = 0; predTarget = 0;
    endtask

    task automatic rand_in();
        stall      = ($urandom_range(0, 3) == 0);
        intWE      = ($urandom_range(0, 31) == 0);
        predTaken  = ($urandom_range(0, 3) == 0);
        brValid    = 2'($urandom);
        brMispred  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
        brTarget   = {32'($urandom), 32'($urandom)};
        intAddr    = 32'($urandom);
        predTarget = 32'($urandom);
    endtask

    task automatic model_reset();
        m_pc = 32'h1000; m_mode = 0; m_wcnt = 0; m_bleft = 0;
        m_port = 0; m_pulse = 0; m_wd = 0;
    endtask

    // Oldest mispredicting channel, -1 if none.
    function automatic int m_winner();
        for (int i = 0; i < 2; i++)
            if (brValid[i] && brMispred[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_npc();
        int w;
        logic [31:0] t;
        w = m_winner();
        if (m_mode == 0) return m_pc;
        if (intWE) return intAddr & ~32'h3;
        if (w >= 0) begin
            t = brTarget[w*32 +: 32];
            return t & ~32'h3;
        end
        if (stall || m_mode == 2) return m_pc;
        if (predTaken) return predTarget & ~32'h3;
        return (m_pc & ~32'h7) + 32'd8;
    endfunction

    function automatic bit m_fv();
        return (m_mode == 1) && !stall;
    endfunction

    // Advance one clock; inputs were set just after the previous edge.
    task automatic tick();
        logic [31:0] npc;
        int w;
        npc = m_npc();
        w   = m_winner();
        @(posedge clk);
        #1;
        m_pc = npc;
        if (m_mode == 0) begin
            m_pulse = 0;
            m_wcnt++;
            if (m_wcnt == WU) begin m_mode = 1; m_wd = 1; end
        end else begin
            m_pulse = !intWE && (w >= 0);
            if (m_pulse) m_port = w;
            if (intWE || w >= 0) begin
                if (BB > 0) begin m_mode = 2; m_bleft = BB; end
            end else if (m_mode == 2) begin
                m_bleft--;
                if (m_bleft == 0) m_mode = 1;
            end
        end
    endtask

    task automatic test_reset();
        clr_in();
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pcOut !== 32'h1000) begin errors++; $display("FAIL reset_pc got %h exp %h", pcOut, 32'h1000); end
        checks++; if (fetchValid !== 1'b0 || warmupDone !== 1'b0 || recoverBrHistory !== 1'b0 || recoverPort !== 1'b0) begin
            errors++; $display("FAIL reset_flags got fv=%b wd=%b rb=%b rp=%b exp all 0", fetchValid, warmupDone, recoverBrHistory, recoverPort);
        end
        rst = 1;
    endtask

    task automatic test_warmup();
        int bad = 0;
        for (int k = 0; k < WU; k++) begin
            rand_in();
            #1;
            if (fetchValid !== 1'b0 || pcOut !== 32'h1000 || predNextPC !== pcOut || warmupDone !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL warmup_hold got %0d bad cycles exp 0", bad); end
        clr_in();
        #1;
        checks++; if (fetchValid !== 1'b1 || pcOut !== 32'h1000 || warmupDone !== 1'b1) begin
            errors++; $display("FAIL warmup_end got fv=%b pc=%h wd=%b exp 1 00001000 1", fetchValid, pcOut, warmupDone);
        end
        tick();
        checks++; if (pcOut !== 32'h1008) begin errors++; $display("FAIL first_incr got %h exp %h", pcOut, 32'h1008); end
    endtask

    task automatic test_increment();
        predTaken = 1; predTarget = 32'h1006;
        tick();
        checks++; if (pcOut !== 32'h1004) begin errors++; $display("FAIL pred_align got %h exp %h", pcOut, 32'h1004); end
        clr_in();
        tick();
        checks++; if (pcOut !== 32'h1008) begin errors++; $display("FAIL block_align got %h exp %h", pcOut, 32'h1008); end
        predTaken = 1; predTarget = 32'hFFFF_FFF8;
        tick();
        clr_in();
        #1;
        checks++; if (predNextPC !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", predNextPC); end
        tick();
        checks++; if (pcOut !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", pcOut); end
    endtask

    task automatic test_dual_mispred();
        brValid = 2'b11; brMispred = 2'b11; brTarget = {32'h3000, 32'h2000};
        tick();
        checks++; if (pcOut !== 32'h2000 || recoverBrHistory !== 1'b1 || recoverPort !== 1'b0) begin
            errors++; $display("FAIL dual_mispred got pc=%h rb=%b rp=%b exp 00002000 1 0", pcOut, recoverBrHistory, recoverPort);
        end
        checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL bubble_fv got %b exp 0", fetchValid); end
        clr_in();
        tick();
        checks++; if (recoverBrHistory !== 1'b0 || pcOut !== 32'h2000 || fetchValid !== 1'b1) begin
            errors++; $display("FAIL pulse_end got rb=%b pc=%h fv=%b exp 0 00002000 1", recoverBrHistory, pcOut, fetchValid);
        end
        // port 0 valid but correctly predicted: port 1 must win
        brValid = 2'b11; brMispred = 2'b10; brTarget = {32'h3000, 32'h2400};
        tick();
        checks++; if (pcOut !== 32'h3000 || recoverBrHistory !== 1'b1 || recoverPort !== 1'b1) begin
            errors++; $display("FAIL port1_mispred got pc=%h rb=%b rp=%b exp 00003000 1 1", pcOut, recoverBrHistory, recoverPort);
        end
        clr_in();
        tick();
    endtask

    task automatic test_int_vs_br();
        intWE = 1; intAddr = 32'h8000;
        brValid = 2'b01; brMispred = 2'b01; brTarget = {32'h0, 32'h2000};
        tick();
        checks++; if (pcOut !== 32'h8000 || recoverBrHistory !== 1'b0) begin
            errors++; $display("FAIL int_wins got pc=%h rb=%b exp 00008000 0", pcOut, recoverBrHistory);
        end
        clr_in();
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] held;
        tick();
        held = pcOut;
        stall = 1; predTaken = 1; predTarget = 32'h5000;
        tick();
        checks++; if (pcOut !== held || fetchValid !== 1'b0) begin
            errors++; $display("FAIL stall_hold got pc=%h fv=%b exp %h 0", pcOut, fetchValid, held);
        end
        brValid = 2'b01; brMispred = 2'b01; brTarget = {32'h0, 32'h4002};
        tick();
        checks++; if (pcOut !== 32'h4000 || recoverBrHistory !== 1'b1) begin
            errors++; $display("FAIL stall_redirect got pc=%h rb=%b exp 00004000 1", pcOut, recoverBrHistory);
        end
        clr_in();
        #1;
        checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL stall_bubble got %b exp 0", fetchValid); end
        tick();
        checks++; if (fetchValid !== 1'b1 || pcOut !== 32'h4000) begin
            errors++; $display("FAIL bubble_exit got fv=%b pc=%h exp 1 00004000", fetchValid, pcOut);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 400; k++) begin
            rand_in();
            #1;
            checks++;
            if (predNextPC !== m_npc() || fetchValid !== m_fv()) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL rand_comb cyc %0d got npc=%h fv=%b exp %h %b", k, predNextPC, fetchValid, m_npc(), m_fv());
            end
            tick();
            checks++;
            if (pcOut !== m_pc || recoverBrHistory !== m_pulse || warmupDone !== m_wd ||
                (m_pulse && recoverPort !== 1'(m_port))) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL rand_state cyc %0d got pc=%h rb=%b rp=%b wd=%b exp %h %b %0d %b",
                                      k, pcOut, recoverBrHistory, recoverPort, warmupDone, m_pc, m_pulse, m_port, m_wd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        clr_in();
        tick(); tick();
        brValid = 2'b01; brMispred = 2'b01; brTarget = {32'h0, 32'h6000};
        tick();
        #1;
        rst = 0;
        #1;
        model_reset();
        checks++; if (pcOut !== 32'h1000 || warmupDone !== 1'b0 || recoverBrHistory !== 1'b0 || fetchValid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got pc=%h wd=%b rb=%b fv=%b exp 00001000 0 0 0", pcOut, warmupDone, recoverBrHistory, fetchValid);
        end
        clr_in();
        rst = 1;
        for (int k = 0; k < WU; k++) begin
            if (fetchValid !== 1'b0 || pcOut !== 32'h1000) bad++;
            tick();
        end
        checks++; if (bad != 0 || fetchValid !== 1'b1) begin
            errors++; $display("FAIL rewarm got %0d bad cycles fv=%b exp 0 1", bad, fetchValid);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_increment();
        test_dual_mispred();
        test_int_vs_br();
        test_stall();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
